rv32im_ex_stage: RTL and testbench

Parametrised execute stage for the RV32 pipeline. It sits between the decode and memory stages and adds four things to the single-cycle integer ALU: the M-extension multiply and divide operations, run iteratively under a stall handshake; registered branch and jump resolution with correct B/J immediates; a valid/bubble pipeline flag; and a forwarding port that is suppressed while a multi-cycle result is pending.

---
 rtl/rv32im_ex_stage_if.sv | 50 +++++
 rtl/rv32im_ex_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_rv32im_ex_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rv32im_ex_stage_if.sv
// Execute-stage port bundle: decode-side inputs and
// registered memory-side outputs plus the forwarding tap.
interface rv32im_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic [XLEN-1:0] pc_in;
  logic [31:0]     iw_in;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] rs2_data_in;
  logic            wb_en_in;
  logic [4:0]      wb_reg_in;
  logic            w_en_in;
  logic            stall_out;
  logic            valid_out;
  logic [XLEN-1:0] alu_out;
  logic [31:0]     iw_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] rs2_data_out;
  logic            wb_en_out;
  logic [4:0]      wb_reg_out;
  logic            w_en_out;
  logic            br_taken_out;
  logic [XLEN-1:0] br_target_out;
  logic            df_ex_enable;
  logic [4:0]      df_ex_reg;
  logic [XLEN-1:0] df_ex_data;

  modport master (
    output valid_in, pc_in, iw_in,
    output rs1_data_in, rs2_data_in,
    output wb_en_in, wb_reg_in, w_en_in,
    input  stall_out, valid_out, alu_out,
    input  iw_out, pc_out, rs2_data_out,
    input  wb_en_out, wb_reg_out, w_en_out,
    input  br_taken_out, br_target_out,
    input  df_ex_enable, df_ex_reg, df_ex_data
  );

  modport slave (
    input  valid_in, pc_in, iw_in,
    input  rs1_data_in, rs2_data_in,
    input  wb_en_in, wb_reg_in, w_en_in,
    output stall_out, valid_out, alu_out,
    output iw_out, pc_out, rs2_data_out,
    output wb_en_out, wb_reg_out, w_en_out,
    output br_taken_out, br_target_out,
    output df_ex_enable, df_ex_reg, df_ex_data
  );
endinterface

// File: rtl/rv32im_ex_stage.sv
// RV32IM execute stage: single-cycle ALU, branch resolve,
// iterative mul/div under a stall handshake.
module rv32im_ex_stage #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input logic              clk,
  input logic              reset,
  rv32im_ex_stage_if.slave ex
);
  localparam int SHW  = $clog2(XLEN);
  localparam int NMUL = XLEN / MUL_BITS;
  localparam int CW   = $clog2(XLEN) + 1;
  localparam int MW   = XLEN + MUL_BITS;

  typedef enum logic [1:0] {
    IDLE, MUL, DIV, DONE
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]   a, b;
  logic [31:0]       iw;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b;
  logic [XLEN-1:0]   imm_u, imm_j;
  logic              is_mop, is_m, stall;

  assign a   = ex.rs1_data_in;
  assign b   = ex.rs2_data_in;
  assign iw  = ex.iw_in;
  assign opc = iw[6:0];
  assign f3  = iw[14:12];
  assign f7  = iw[31:25];

  assign imm_i = XLEN'($signed(iw[31:20]));
  assign imm_s = XLEN'($signed({iw[31:25], iw[11:7]}));
  assign imm_b = XLEN'($signed({iw[31], iw[7],
                   iw[30:25], iw[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({iw[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({iw[31], iw[19:12],
                   iw[20], iw[30:21], 1'b0}));

  assign is_mop = (opc == 7'b0110011) &&
                  (f7 == 7'b0000001);
  assign is_m   = ex.valid_in & is_mop;
  assign stall  = is_m & (state_q != DONE);

  // operand signedness per M-op; magnitudes feed the iterators
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;

  assign a_sgn = f3[2] ? !f3[0] : (f3 != 3'b011);
  assign b_sgn = f3[2] ? !f3[0] : !f3[1];
  assign a_neg = a_sgn & a[XLEN-1];
  assign b_neg = b_sgn & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign div_zero = (b == '0);
  assign div_ovf  = !f3[0] && (b == '1) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}});

  logic [2*XLEN-1:0] acc_q, mul_next, div_next;
  logic [XLEN-1:0]   opb_q;
  logic [CW-1:0]     cnt_q;
  logic              negp_q, negr_q;
  logic [MW-1:0]     msum;
  logic [XLEN:0]     dsh, dsub;

  assign msum = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
              + MW'(opb_q) * MW'(acc_q[MUL_BITS-1:0]);
  assign mul_next = {msum, acc_q[XLEN-1:MUL_BITS]};
  assign dsh  = acc_q[2*XLEN-1:XLEN-1];
  assign dsub = dsh - {1'b0, opb_q};
  assign div_next = dsub[XLEN]
    ? {dsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
    : {dsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (is_m)
        state_d = !f3[2] ? MUL :
                  (div_zero | div_ovf) ? DONE : DIV;
      MUL:  if (cnt_q == CW'(NMUL-1)) state_d = DONE;
      DIV:  if (cnt_q == CW'(XLEN-1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (is_m) begin
          cnt_q  <= '0;
          opb_q  <= b_mag;
          negp_q <= a_neg ^ b_neg;
          negr_q <= a_neg;
          acc_q  <= {{XLEN{1'b0}}, a_mag};
          // special cases preload the final quotient/remainder
          if (f3[2] && div_zero) begin
            acc_q  <= {a, {XLEN{1'b1}}};
            negp_q <= 1'b0;
            negr_q <= 1'b0;
          end else if (f3[2] && div_ovf) begin
            acc_q  <= {{XLEN{1'b0}}, a};
            negp_q <= 1'b0;
            negr_q <= 1'b0;
          end
        end
        MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, m_res;

  assign prod = negp_q ? -acc_q : acc_q;
  assign quo  = negp_q ? -acc_q[XLEN-1:0]
                       : acc_q[XLEN-1:0];
  assign rem  = negr_q ? -acc_q[2*XLEN-1:XLEN]
                       : acc_q[2*XLEN-1:XLEN];
  assign m_res = (f3 == 3'b000) ? prod[XLEN-1:0] :
                 !f3[2]         ? prod[2*XLEN-1:XLEN] :
                 !f3[1]         ? quo : rem;

  logic [XLEN-1:0] alu_res, br_tgt, op2;
  logic [SHW-1:0]  sh;
  logic            br_c, op_r, op_i;

  assign op_r = (opc == 7'b0110011);
  assign op_i = (opc == 7'b0010011);
  assign op2  = op_r ? b : imm_i;
  assign sh   = op2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    br_c    = 1'b0;
    br_tgt  = '0;
    unique case (1'b1)
      op_r | op_i: begin
        unique case (f3)
          3'b000: alu_res = (op_r & iw[30]) ? a - op2
                                            : a + op2;
          3'b001: alu_res = a << sh;
          3'b010: alu_res =
            XLEN'($signed(a) < $signed(op2));
          3'b011: alu_res = XLEN'(a < op2);
          3'b100: alu_res = a ^ op2;
          3'b101: alu_res = iw[30]
            ? XLEN'($signed(a) >>> sh) : a >> sh;
          3'b110: alu_res = a | op2;
          default: alu_res = a & op2;
        endcase
      end
      opc == 7'b0000011: alu_res = a + imm_i;
      opc == 7'b0100011: alu_res = a + imm_s;
      opc == 7'b0110111: alu_res = imm_u;
      opc == 7'b0010111: alu_res = ex.pc_in + imm_u;
      opc == 7'b1101111: begin
        alu_res = ex.pc_in + XLEN'(4);
        br_c    = 1'b1;
        br_tgt  = ex.pc_in + imm_j;
      end
      opc == 7'b1100111: begin
        alu_res = ex.pc_in + XLEN'(4);
        br_c    = 1'b1;
        br_tgt  = (a + imm_i) & ~XLEN'(1);
      end
      opc == 7'b1100011: begin
        br_tgt = ex.pc_in + imm_b;
        unique case (f3)
          3'b000: br_c = (a == b);
          3'b001: br_c = (a != b);
          3'b100: br_c = $signed(a) < $signed(b);
          3'b101: br_c = !($signed(a) < $signed(b));
          3'b110: br_c = (a < b);
          3'b111: br_c = !(a < b);
          default: br_c = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] result;
  logic            ld;

  assign result = is_mop ? m_res : alu_res;
  assign ld     = ex.valid_in & !stall;

  assign ex.stall_out    = stall;
  assign ex.df_ex_reg    = ex.wb_reg_in;
  assign ex.df_ex_data   = result;
  assign ex.df_ex_enable = ld & ex.wb_en_in &
                           (ex.wb_reg_in != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex.valid_out     <= 1'b0;
      ex.alu_out       <= '0;
      ex.iw_out        <= '0;
      ex.pc_out        <= '0;
      ex.rs2_data_out  <= '0;
      ex.wb_en_out     <= 1'b0;
      ex.wb_reg_out    <= '0;
      ex.w_en_out      <= 1'b0;
      ex.br_taken_out  <= 1'b0;
      ex.br_target_out <= '0;
    end else begin
      ex.valid_out     <= ld;
      ex.alu_out       <= result;
      ex.iw_out        <= iw;
      ex.pc_out        <= ex.pc_in;
      ex.rs2_data_out  <= b;
      ex.wb_en_out     <= ld & ex.wb_en_in;
      ex.wb_reg_out    <= ex.wb_reg_in;
      ex.w_en_out      <= ld & ex.w_en_in;
      ex.br_taken_out  <= ld & br_c;
      ex.br_target_out <= br_tgt;
    end
  end
endmodule

// File: tb/tb_rv32im_ex_stage.sv
// Directed bench for rv32im_ex_stage (XLEN=32, MUL_BITS=1).
// Tasks per feature; expected values hand-computed.
module tb_rv32im_ex_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32im_ex_stage_if #(.XLEN(32)) ex ();

  rv32im_ex_stage #(.XLEN(32), .MUL_BITS(1)) dut (
    .clk(clk),
    .reset(reset),
    .ex(ex)
  );

  function automatic logic [31:0] r_op(
    input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] b_op(
    input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] iw,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] pc, input logic [4:0] rd);
    ex.valid_in    = 1'b1;
    ex.iw_in       = iw;
    ex.rs1_data_in = a;
    ex.rs2_data_in = b;
    ex.pc_in       = pc;
    ex.wb_en_in    = 1'b1;
    ex.wb_reg_in   = rd;
    ex.w_en_in     = 1'b0;
  endtask

  task automatic test_reset;
    ex.valid_in = 1'b0;
    ex.iw_in = '0; ex.pc_in = '0;
    ex.rs1_data_in = '0; ex.rs2_data_in = '0;
    ex.wb_en_in = 1'b0; ex.wb_reg_in = '0;
    ex.w_en_in = 1'b0;
    reset = 1'b1;
    step; step;
    tests++; if (ex.valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ex.valid_out); end
    tests++; if (ex.alu_out !== 32'd0) begin fails++; $display("FAIL reset_alu: got %h want 0", ex.alu_out); end
    tests++; if (ex.stall_out !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", ex.stall_out); end
    tests++; if ({ex.wb_en_out, ex.w_en_out, ex.br_taken_out} !== 3'b000) begin fails++; $display("FAIL reset_en: got %b want 000", {ex.wb_en_out, ex.w_en_out, ex.br_taken_out}); end
    reset = 1'b0;
  endtask

  task automatic test_alu;
    logic [31:0] iws [8];
    logic [31:0] as [8];
    logic [31:0] bs [8];
    logic [31:0] exps [8];
    iws[0] = r_op(7'h00, 3'b000); as[0] = 5;  bs[0] = 7;  exps[0] = 32'd12;
    iws[1] = r_op(7'h20, 3'b000); as[1] = 5;  bs[1] = 7;  exps[1] = 32'hFFFF_FFFE;
    iws[2] = r_op(7'h20, 3'b101); as[2] = 32'h8000_0000; bs[2] = 4; exps[2] = 32'hF800_0000;
    iws[3] = r_op(7'h00, 3'b010); as[3] = 32'hFFFF_FFFF; bs[3] = 1; exps[3] = 32'd1;
    iws[4] = r_op(7'h00, 3'b011); as[4] = 32'hFFFF_FFFF; bs[4] = 1; exps[4] = 32'd0;
    iws[5] = r_op(7'h00, 3'b001); as[5] = 1;  bs[5] = 33; exps[5] = 32'd2;
    iws[6] = {12'hFFF, 5'd1, 3'b000, 5'd3, 7'b0010011}; as[6] = 5; bs[6] = 0; exps[6] = 32'd4;
    iws[7] = {20'h12345, 5'd3, 7'b0110111}; as[7] = 0; bs[7] = 0; exps[7] = 32'h1234_5000;
    for (int i = 0; i < 8; i++) begin
      drive(iws[i], as[i], bs[i], 32'h40, 5'd3);
      #1;
      tests++; if (ex.stall_out !== 1'b0) begin fails++; $display("FAIL alu%0d_stall: got %b want 0", i, ex.stall_out); end
      step;
      tests++; if (ex.alu_out !== exps[i]) begin fails++; $display("FAIL alu%0d: got %h want %h", i, ex.alu_out, exps[i]); end
      tests++; if (ex.valid_out !== 1'b1) begin fails++; $display("FAIL alu%0d_valid: got %b want 1", i, ex.valid_out); end
    end
    ex.wb_reg_in = 5'd0;
    #1;
    tests++; if (ex.df_ex_enable !== 1'b0) begin fails++; $display("FAIL df_x0: got %b want 0", ex.df_ex_enable); end
    ex.valid_in = 1'b0;
    step;
    tests++; if (ex.valid_out !== 1'b0) begin fails++; $display("FAIL bubble: got %b want 0", ex.valid_out); end
  endtask

  task automatic run_mop(input string name,
    input logic [31:0] iw, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] exp,
    input int exp_stall);
    int n;
    n = 0;
    drive(iw, a, b, 32'h80, 5'd7);
    #1;
    while (ex.stall_out === 1'b1 && n < 200) begin
      n++;
      tests++; if (ex.df_ex_enable !== 1'b0) begin fails++; $display("FAIL %s_df_stall: got %b want 0", name, ex.df_ex_enable); end
      step;
      tests++; if (ex.valid_out !== 1'b0) begin fails++; $display("FAIL %s_valid_stall: got %b want 0", name, ex.valid_out); end
    end
    tests++; if (n !== exp_stall) begin fails++; $display("FAIL %s_stall_cycles: got %0d want %0d", name, n, exp_stall); end
    tests++; if (ex.df_ex_data !== exp) begin fails++; $display("FAIL %s_df_data: got %h want %h", name, ex.df_ex_data, exp); end
    step;
    tests++; if (ex.alu_out !== exp) begin fails++; $display("FAIL %s: got %h want %h", name, ex.alu_out, exp); end
    tests++; if (ex.valid_out !== 1'b1) begin fails++; $display("FAIL %s_valid: got %b want 1", name, ex.valid_out); end
    ex.valid_in = 1'b0;
  endtask

  task automatic test_muldiv;
    run_mop("mulh", r_op(7'h01, 3'b001), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_mop("mul", r_op(7'h01, 3'b000), 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);
    run_mop("div", r_op(7'h01, 3'b100), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mop("rem", r_op(7'h01, 3'b110), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_mop("divu_zero", r_op(7'h01, 3'b101), 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run_mop("div_ovf", r_op(7'h01, 3'b100), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
  endtask

  task automatic test_back_to_back;
    run_mop("b2b_remu", r_op(7'h01, 3'b111), 32'd100, 32'd7, 32'd2, 33);
    run_mop("b2b_mulhu", r_op(7'h01, 3'b011), 32'hFFFF_FFFF, 32'h0000_0002, 32'd1, 33);
  endtask

  task automatic test_branch;
    drive(b_op(13'h1FF8, 3'b101), 32'hFFFF_FFFF, 32'd1, 32'h100, 5'd0);
    step;
    tests++; if (ex.br_taken_out !== 1'b0) begin fails++; $display("FAIL bge: got %b want 0", ex.br_taken_out); end
    drive(b_op(13'h1FF8, 3'b110), 32'hFFFF_FFFF, 32'd1, 32'h100, 5'd0);
    step;
    tests++; if (ex.br_taken_out !== 1'b0) begin fails++; $display("FAIL bltu: got %b want 0", ex.br_taken_out); end
    drive(b_op(13'h1FF8, 3'b100), 32'hFFFF_FFFF, 32'd1, 32'h100, 5'd0);
    step;
    tests++; if (ex.br_taken_out !== 1'b1) begin fails++; $display("FAIL blt: got %b want 1", ex.br_taken_out); end
    tests++; if (ex.br_target_out !== 32'hF8) begin fails++; $display("FAIL blt_target: got %h want %h", ex.br_target_out, 32'hF8); end
    tests++; if (ex.alu_out !== 32'd0) begin fails++; $display("FAIL blt_alu: got %h want 0", ex.alu_out); end
    drive({12'd2, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h1001, 32'd0, 32'h200, 5'd1);
    step;
    tests++; if (ex.br_target_out !== 32'h1002) begin fails++; $display("FAIL jalr_target: got %h want %h", ex.br_target_out, 32'h1002); end
    tests++; if (ex.alu_out !== 32'h204) begin fails++; $display("FAIL jalr_link: got %h want %h", ex.alu_out, 32'h204); end
    tests++; if (ex.br_taken_out !== 1'b1) begin fails++; $display("FAIL jalr_taken: got %b want 1", ex.br_taken_out); end
    drive({1'b0, 10'd8, 1'b0, 8'd0, 5'd1, 7'b1101111}, 32'd0, 32'd0, 32'h300, 5'd1);
    step;
    tests++; if (ex.br_target_out !== 32'h310) begin fails++; $display("FAIL jal_target: got %h want %h", ex.br_target_out, 32'h310); end
    tests++; if (ex.alu_out !== 32'h304) begin fails++; $display("FAIL jal_link: got %h want %h", ex.alu_out, 32'h304); end
    ex.valid_in = 1'b0;
    step;
    tests++; if (ex.br_taken_out !== 1'b0) begin fails++; $display("FAIL bubble_br: got %b want 0", ex.br_taken_out); end
  endtask

  task automatic test_reset_mid;
    drive(r_op(7'h01, 3'b100), 32'd100, 32'd3, 32'h500, 5'd9);
    #1;
    repeat (5) step;
    tests++; if (ex.stall_out !== 1'b1) begin fails++; $display("FAIL mid_stall: got %b want 1", ex.stall_out); end
    reset = 1'b1;
    step;
    tests++; if ({ex.valid_out, ex.wb_en_out, ex.w_en_out, ex.br_taken_out} !== 4'b0000) begin fails++; $display("FAIL rst_mid_flags: got %b want 0000", {ex.valid_out, ex.wb_en_out, ex.w_en_out, ex.br_taken_out}); end
    tests++; if ((ex.alu_out | ex.pc_out | ex.iw_out | ex.rs2_data_out | ex.br_target_out | 32'(ex.wb_reg_out)) !== 32'd0) begin fails++; $display("FAIL rst_mid_data: alu=%h pc=%h iw=%h want all 0", ex.alu_out, ex.pc_out, ex.iw_out); end
    ex.valid_in = 1'b0;
    #1;
    tests++; if (ex.stall_out !== 1'b0) begin fails++; $display("FAIL rst_mid_stall: got %b want 0", ex.stall_out); end
    reset = 1'b0;
    drive(r_op(7'h00, 3'b000), 32'd5, 32'd7, 32'h600, 5'd3);
    #1;
    tests++; if (ex.stall_out !== 1'b0) begin fails++; $display("FAIL post_rst_stall: got %b want 0", ex.stall_out); end
    tests++; if (ex.df_ex_enable !== 1'b1) begin fails++; $display("FAIL post_rst_df: got %b want 1", ex.df_ex_enable); end
    step;
    tests++; if (ex.alu_out !== 32'd12 || ex.valid_out !== 1'b1) begin fails++; $display("FAIL post_rst_add: got %h/%b want 0000000c/1", ex.alu_out, ex.valid_out); end
    ex.valid_in = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_muldiv;
    test_back_to_back;
    test_branch;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
